alu_pipe_mc: RTL and testbench

//  Parametrised, registered ALU for the superscalar execution lanes. Same 4-bit

---
 rtl/alu_pipe_mc.sv | 174 +++++++++++++++++
 tb/tb_alu_pipe_mc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_mc.sv
// Registered ALU lane with NZCV flags, tag pass-through and valid/ready on both sides.
// Single-cycle ops complete on the accept edge; op 7 runs an iterative shift-add multiply.
module alu_pipe_mc #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [3:0]       alu_fun,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

    state_t state, state_next;

    logic              accept;
    logic              pop;
    logic              mul_start;
    logic              mul_done;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SH_W-1:0]   sh;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   mul_tag;
    logic [WIDTH:0]     acc_sum;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign mul_start = accept && (alu_fun == 4'h7) && (MUL_EN != 0);
    assign mul_done  = (state == MUL_BUSY) && (cnt == '0);
    assign busy      = (state == MUL_BUSY);
    assign negative  = resultado[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mul_start) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Single-cycle function unit
    assign a_s  = data_a;
    assign b_s  = data_b;
    assign sh   = data_b[SH_W-1:0];
    assign sum  = {1'b0, data_a} + {1'b0, data_b};
    assign diff = {1'b0, data_a} - {1'b0, data_b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_fun)
            4'h0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != data_a[WIDTH-1]);
            end
            4'h1: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != data_a[WIDTH-1]);
            end
            4'h2: alu_res = data_a << sh;
            4'h3: alu_res = data_a >> sh;
            4'h4: alu_res = $unsigned(a_s >>> sh);
            4'h5: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'h6: alu_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
            4'h8: alu_res = data_a & data_b;
            4'h9: alu_res = data_a | data_b;
            4'ha: alu_res = ~data_a;
            4'hb: alu_res = data_a ^ data_b;
            4'hc: alu_res = ~(data_a & data_b);
            4'hd: alu_res = ~(data_a | data_b);
            4'he: alu_res = ~(data_a ^ data_b);
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == '0);
        if (alu_fun == 4'hf) alu_z = (data_a == data_b);
    end

    // Multiplier step: add into the upper half, then shift the whole accumulator right
    assign acc_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk) begin
        if (mul_start) begin
            mcand   <= data_a;
            mplier  <= data_b;
            acc     <= '0;
            mul_tag <= in_tag;
        end else if ((state == MUL_BUSY) && (cnt != '0)) begin
            acc    <= {acc_sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (mul_start) begin
            cnt <= CNT_W'(WIDTH);
        end else if ((state == MUL_BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            resultado <= '0;
            out_tag   <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept && !mul_start) begin
            out_valid <= 1'b1;
            resultado <= alu_res;
            out_tag   <= in_tag;
            zero      <= alu_z;
            carry     <= alu_c;
            overflow  <= alu_v;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            resultado <= acc[WIDTH-1:0];
            out_tag   <= mul_tag;
            zero      <= (acc[WIDTH-1:0] == '0);
            carry     <= (acc[2*WIDTH-1:WIDTH] != '0);
            overflow  <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe_mc.sv
// Directed bench for alu_pipe_mc (WIDTH=32): flags, shifts, multiply timing, handshake and reset abort.
module tb_alu_pipe_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  alu_fun;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] resultado;
    logic [3:0]  out_tag;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_pipe_mc #(.WIDTH(32), .TAG_W(4), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_a(data_a), .data_b(data_b), .alu_fun(alu_fun), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .resultado(resultado),
        .out_tag(out_tag), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        alu_fun  = fun;
        data_a   = a;
        data_b   = b;
        in_tag   = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [31:0] r, input logic z,
                             input logic n, input logic c, input logic v);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_res"}, resultado, r);
        check({tag, "_z"}, zero, z);
        check({tag, "_n"}, negative, n);
        check({tag, "_c"}, carry, c);
        check({tag, "_v"}, overflow, v);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_a    = '0;
        data_b    = '0;
        alu_fun   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res", resultado, 32'h0);
        check("rst_tag", out_tag, 4'h0);
        check("rst_flags", {zero, negative, carry, overflow}, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        tick();

        issue(4'h0, 32'hFFFF_FFFF, 32'h1, 4'h1);
        check_res("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("add_tag", out_tag, 4'h1);

        issue(4'h1, 32'h8000_0000, 32'h1, 4'h2);
        check_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sub_tag", out_tag, 4'h2);
        issue(4'h1, 32'h1, 32'h2, 4'h3);
        check_res("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(4'hF, 32'h1234, 32'h1234, 4'h4);
        check_res("cmp_eq", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'hF, 32'h1234, 32'h1235, 4'h4);
        check_res("cmp_ne", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        issue(4'h4, 32'hF000_0000, 32'h24, 4'h5);
        check_res("asr", 32'hFF00_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'h3, 32'hF000_0000, 32'h24, 4'h5);
        check_res("shr", 32'h0F00_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'h2, 32'h1, 32'h3F, 4'h5);
        check_res("shl", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'h5, 32'hFFFF_FFFF, 32'h1, 4'h6);
        check_res("slt", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'h6, 32'hFFFF_FFFF, 32'h1, 4'h6);
        check_res("sltu", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'hE, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'h7);
        check_res("xnor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'hA, 32'h0, 32'h0, 4'h7);
        check_res("not", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'hC, 32'hFFFF_0000, 32'hFF00_FF00, 4'h7);
        check_res("nand", 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multiply: out_valid must rise exactly 33 edges after the accept edge
        issue(4'h7, 32'h0001_0000, 32'h0001_0000, 4'hA);
        for (int i = 0; i < 33; i++) begin
            check("mul_busy", busy, 1'b1);
            check("mul_in_ready", in_ready, 1'b0);
            check("mul_out_valid", out_valid, 1'b0);
            tick();
        end
        check_res("mul_big", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mul_big_tag", out_tag, 4'hA);
        check("mul_big_idle", busy, 1'b0);
        issue(4'h7, 32'd7, 32'd6, 4'hB);
        for (int i = 0; i < 33; i++) tick();
        check_res("mul_small", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mul_small_tag", out_tag, 4'hB);

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            alu_fun  = 4'h0;
            data_a   = 32'(i * 16 + 1);
            data_b   = 32'd2;
            in_tag   = 4'(i);
            in_valid = 1'b1;
            check("b2b_in_ready", in_ready, 1'b1);
            tick();
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_tag", out_tag, 4'(i));
            check("b2b_res", resultado, 32'(i * 16 + 3));
        end

        // Stall with a pending op
        data_a    = 32'd100;
        data_b    = 32'd1;
        in_tag    = 4'h9;
        out_ready = 1'b0;
        #1;
        check("stall_in_ready0", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", out_valid, 1'b1);
            check("stall_res", resultado, 32'd51);
            check("stall_tag", out_tag, 4'h3);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("resume_tag", out_tag, 4'h9);
        check("resume_res", resultado, 32'd101);
        tick();
        check("drain_valid", out_valid, 1'b0);

        // Reset in the middle of a multiply
        issue(4'h7, 32'd3, 32'd5, 4'hC);
        for (int i = 0; i < 9; i++) tick();
        check("abort_pre_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        begin
            logic stale;
            stale = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) stale = 1'b1;
            end
            check("abort_no_stale", stale, 1'b0);
        end
        check("abort_res", resultado, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
